// File: rtl/fetch_pkg.sv
// Shared widths and the fetch FIFO payload type for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INST_W  = 32;
  localparam int unsigned PC_STEP = 4;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetched {inst, pc} entries; flush beats push in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= CNT_W'(count + CNT_W'(do_push) - CNT_W'(do_pop));
    end
  end

  // Payload storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives pc_next, issues in-order imem requests, buffers responses for decode.
// Optional same-cycle response-to-decode bypass enabled by defining IFU_BYPASS_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_next,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] drop;
  logic [PC_W-1:0]  resp_pc;
  logic             armed;
  logic [SUM_W-1:0] occupancy;
  logic             accept;
  logic             resp_live;
  logic             push;
  logic             pop;
  fetch_entry_t     head;
  fetch_entry_t     resp_entry;

  // Live slots: buffered entries plus requests whose responses will be kept.
  assign occupancy      = SUM_W'(SUM_W'(count) + SUM_W'(inflight) - SUM_W'(drop));
  assign imem_req_valid = armed && !redirect && (occupancy < SUM_W'(DEPTH));
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign resp_live      = imem_resp_valid && (drop == '0) && !redirect;
  assign resp_entry     = '{inst: imem_resp_data, pc: resp_pc};
  assign pop            = (count != '0) && inst_ready;

`ifdef IFU_BYPASS_EN
  logic bypass;
  assign bypass     = resp_live && (count == '0);
  assign inst_valid = (count != '0) || bypass;
  assign inst_data  = bypass ? imem_resp_data : head.inst;
  assign inst_pc    = bypass ? resp_pc : head.pc;
  assign push       = resp_live && !(bypass && inst_ready);
`else
  assign inst_valid = (count != '0);
  assign inst_data  = head.inst;
  assign inst_pc    = head.pc;
  assign push       = resp_live;
`endif

  always_comb begin
    pc_next = pc;
    if (!armed)        pc_next = '0;
    else if (redirect) pc_next = redirect_pc;
    else if (accept)   pc_next = PC_W'(pc + PC_W'(PC_STEP));
  end

  // armed keeps requests and pc_next quiet until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      inflight <= '0;
      drop     <= '0;
      resp_pc  <= '0;
    end else begin
      armed    <= 1'b1;
      inflight <= CNT_W'(inflight + CNT_W'(accept) - CNT_W'(imem_resp_valid));
      if (redirect) begin
        drop    <= CNT_W'(inflight - CNT_W'(imem_resp_valid));
        resp_pc <= redirect_pc;
      end else if (imem_resp_valid) begin
        if (drop != '0) drop    <= CNT_W'(drop - CNT_W'(1));
        else            resp_pc <= PC_W'(resp_pc + PC_W'(PC_STEP));
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (resp_entry),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit with a PC register and latency-modelled imem.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_next;
  logic              redirect = 1'b0;
  logic [PC_W-1:0]   redirect_pc = '0;
  logic              imem_req_valid;
  logic              imem_req_ready = 1'b0;
  logic [PC_W-1:0]   imem_req_addr;
  logic              imem_resp_valid = 1'b0;
  logic [INST_W-1:0] imem_resp_data = '0;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [INST_W-1:0] inst_data;
  logic [PC_W-1:0]   inst_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_next(pc_next),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
  );

  // Environment PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else        pc <= pc_next;
  end

  typedef struct { int due; logic [INST_W-1:0] data; int ep; } resp_t;
  typedef struct { logic [PC_W-1:0] pc; logic [INST_W-1:0] inst; } exp_t;

  resp_t           pend[$];
  exp_t            sb[$];
  exp_t            mon_e;
  resp_t           cur_r;
  int              cyc = 0, last_due = 0, epoch = 0, arrived = 0, cur_ep = -1;
  logic [PC_W-1:0] fetch_pc = '0;
  int              n_checks = 0, n_pass = 0;
  int              redir_pct = 0, rdy_pct = 100, mrdy_pct = 100, lat_max = 1;
  logic            redir_on_resp = 1'b0, redir_once = 1'b0;
  logic [PC_W-1:0] redir_once_pc = '0;

  function automatic logic [INST_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return {a ^ 16'hA5C3, ~a} + 32'h0000_0137;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard on every accepted decode handshake.
  always begin
    @(negedge clk);
    #2;
    if (rst_n === 1'b1 && !redirect && inst_valid && inst_ready) begin
      if (sb.size() == 0) chk("spurious_inst_valid", inst_valid, 1'b0);
      else begin
        mon_e = sb.pop_front();
        chk("inst_pc", inst_pc, mon_e.pc);
        chk("inst_data", inst_data, mon_e.inst);
      end
    end
  end

  task automatic step();
    logic            live, acc, pop, exp_req, exp_iv;
    logic [PC_W-1:0] exp_pcn;
    int              lat, due;
    @(posedge clk);
    cyc++;
    #1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    cur_ep          = -1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      cur_r           = pend.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = cur_r.data;
      cur_ep          = cur_r.ep;
    end
    redirect    = ($urandom_range(99) < redir_pct) || (redir_on_resp && imem_resp_valid) || redir_once;
    redirect_pc = redir_once ? redir_once_pc : (16'($urandom) & 16'hFFFC);
    redir_once  = 1'b0;
    inst_ready     = $urandom_range(99) < rdy_pct;
    imem_req_ready = $urandom_range(99) < mrdy_pct;
    @(negedge clk);
    live    = imem_resp_valid && (cur_ep == epoch) && !redirect;
    exp_req = !redirect && (sb.size() < DEPTH);
    exp_iv  = arrived > 0;
`ifdef IFU_BYPASS_EN
    exp_iv  = exp_iv || live;
`endif
    chk("imem_req_valid", imem_req_valid, exp_req);
    chk("inst_valid", inst_valid, exp_iv);
    exp_pcn = redirect ? redirect_pc : ((exp_req && imem_req_ready) ? pc + 16'd4 : pc);
    chk("pc_next", pc_next, exp_pcn);
    acc = imem_req_valid && imem_req_ready;
    pop = inst_valid && inst_ready;
    if (redirect) begin
      epoch++;
      sb.delete();
      arrived  = 0;
      fetch_pc = redirect_pc;
    end else begin
      arrived = arrived + int'(live) - int'(pop);
      if (acc) begin
        chk("imem_req_addr", imem_req_addr, fetch_pc);
        sb.push_back('{pc: fetch_pc, inst: mem_word(fetch_pc)});
        fetch_pc = fetch_pc + 16'd4;
        lat = $urandom_range(lat_max, 1);
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        pend.push_back('{due: due, data: mem_word(imem_req_addr), ep: epoch});
        last_due = due;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_model();
    pend.delete();
    sb.delete();
    arrived  = 0;
    epoch++;
    fetch_pc = '0;
    last_due = cyc;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    redirect = 1'b0; imem_resp_valid = 1'b0; inst_ready = 1'b0; imem_req_ready = 1'b0;
    #1;
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_pc_next", pc_next, 16'h0000);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #12;
    chk("por_inst_valid", inst_valid, 1'b0);
    chk("por_req_valid", imem_req_valid, 1'b0);
    chk("por_pc_next", pc_next, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(20);                                   // streaming, latency 1
    rdy_pct = 0;   run(6);                     // decode stall fills the FIFO
    rdy_pct = 100; run(10);
    lat_max = 2;   run(4);
    redir_once = 1'b1; redir_once_pc = 16'h0100; run(12);
    redir_on_resp = 1'b1; run(6); redir_on_resp = 1'b0; run(6);
    lat_max = 1;
    redir_once = 1'b1; redir_once_pc = 16'hFFF8; run(12);   // wrap through 0xFFFC
    redir_pct = 5; rdy_pct = 70; mrdy_pct = 70; lat_max = 3;
    run(400);
    redir_pct = 0; rdy_pct = 0; mrdy_pct = 100; run(6);
    async_reset();
    rdy_pct = 100; lat_max = 1; run(20);
    rdy_pct = 60; mrdy_pct = 80; lat_max = 3; redir_pct = 3; run(200);

    redir_pct = 0; rdy_pct = 100; mrdy_pct = 0;
    for (int i = 0; i < 30 && sb.size() > 0; i++) step();
    chk("drain_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
